// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the dp sequencer: MIPS opcode/funct values, ALU op codes
// and the sequencer state enum.
package dp_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        WB,
        DONE
    } state_e;

endpackage

// File: rtl/dp_instr_decode.sv
// Combinational MIPS decoder: maps an instruction word to dp control fields,
// flags instructions that can raise an overflow trap and flags undecodable ones.
module dp_instr_decode
    import dp_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  read1,
    output logic [4:0]  read2,
    output logic [4:0]  write,
    output logic [3:0]  op,
    output logic        sel,
    output logic        may_trap,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        read1    = instr[25:21];
        read2    = instr[20:16];
        write    = '0;
        op       = '0;
        sel      = 1'b0;
        may_trap = 1'b0;
        illegal  = 1'b0;
        if (opcode == OPC_RTYPE) begin
            write = instr[15:11];
            case (funct)
                FN_AND: op = ALU_AND;
                FN_OR:  op = ALU_OR;
                FN_ADD: begin op = ALU_ADD; may_trap = 1'b1; end
                FN_SUB: begin op = ALU_SUB; may_trap = 1'b1; end
                FN_SLT: op = ALU_SLT;
                FN_NOR: op = ALU_NOR;
                default: begin write = '0; illegal = 1'b1; end
            endcase
        end else begin
            write = instr[20:16];
            sel   = 1'b1;
            case (opcode)
                OPC_ANDI: op = ALU_AND;
                OPC_ORI:  op = ALU_OR;
                OPC_ADDI: begin op = ALU_ADD; may_trap = 1'b1; end
                OPC_SLTI: op = ALU_SLT;
                default: begin write = '0; sel = 1'b0; illegal = 1'b1; end
            endcase
        end
    end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle control unit: accepts one instruction, drives dp control fields
// through DECODE/EXEC/WB, captures the result and reports completion.
module dp_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  read1,
    output logic [4:0]  read2,
    output logic [4:0]  write,
    output logic [3:0]  op,
    output logic [15:0] inm,
    output logic        sel,
    output logic        reg_we,
    input  logic [31:0] dp_result,
    input  logic        dp_zero,
    input  logic        dp_overflow,
    input  logic        dp_carry,
    output logic        done,
    output logic        illegal,
    output logic        ovf_trap,
    output logic [31:0] result_q,
    output logic [2:0]  flags_q
);

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_d;
    logic [2:0]  flags_d;
    logic        illegal_q, illegal_d;
    logic        ovf_trap_q, ovf_trap_d;
    logic        done_q, done_d;

    logic [4:0]  dec_read1, dec_read2, dec_write;
    logic [3:0]  dec_op;
    logic        dec_sel, dec_may_trap, dec_illegal;
    logic        accept, trap, ctrl_en;

    dp_instr_decode u_decode (
        .instr    (instr_q),
        .read1    (dec_read1),
        .read2    (dec_read2),
        .write    (dec_write),
        .op       (dec_op),
        .sel      (dec_sel),
        .may_trap (dec_may_trap),
        .illegal  (dec_illegal)
    );

    assign accept = (state_q == IDLE) && instr_valid;
    assign trap   = (state_q == WB) && dec_may_trap && dp_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = DECODE;
            DECODE:  state_d = dec_illegal ? DONE : EXEC;
            EXEC:    if (cnt_q == CNT_LAST) state_d = WB;
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done is registered out of DONE, so it is seen one edge after DONE is entered
    always_comb begin
        instr_d    = accept ? instr : instr_q;
        cnt_d      = (state_q == EXEC) ? cnt_q + 4'd1 : '0;
        result_d   = (state_q == WB) ? dp_result : result_q;
        flags_d    = (state_q == WB) ? {dp_zero, dp_overflow, dp_carry} : flags_q;
        illegal_d  = illegal_q;
        ovf_trap_d = ovf_trap_q;
        if (accept) begin
            illegal_d  = 1'b0;
            ovf_trap_d = 1'b0;
        end else begin
            if ((state_q == DECODE) && dec_illegal) illegal_d = 1'b1;
            if (trap) ovf_trap_d = 1'b1;
        end
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            illegal_q  <= 1'b0;
            ovf_trap_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            illegal_q  <= illegal_d;
            ovf_trap_q <= ovf_trap_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        ctrl_en     = (state_q == DECODE) || (state_q == EXEC) || (state_q == WB);
        instr_ready = rst_n && (state_q == IDLE);
        read1       = ctrl_en ? dec_read1 : '0;
        read2       = ctrl_en ? dec_read2 : '0;
        write       = ctrl_en ? dec_write : '0;
        op          = ctrl_en ? dec_op : '0;
        sel         = ctrl_en && dec_sel;
        inm         = ctrl_en ? instr_q[15:0] : '0;
        reg_we      = (state_q == WB) && !trap && (dec_write != '0);
        done        = done_q;
        illegal     = illegal_q;
        ovf_trap    = ovf_trap_q;
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed self-checking bench for dp_sequencer (EXEC_CYCLES=1 and 3 instances).
module tb_dp_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] dp_result;
    logic        dp_zero, dp_overflow, dp_carry;

    logic        valid1, ready1;
    logic [31:0] instr1;
    logic [4:0]  rd1_1, rd2_1, wr_1;
    logic [3:0]  op_1;
    logic [15:0] inm_1;
    logic        sel_1, we_1, done_1, ill_1, trap_1;
    logic [31:0] res_1;
    logic [2:0]  flg_1;

    logic        valid3, ready3;
    logic [31:0] instr3;
    logic [4:0]  rd1_3, rd2_3, wr_3;
    logic [3:0]  op_3;
    logic [15:0] inm_3;
    logic        sel_3, we_3, done_3, ill_3, trap_3;
    logic [31:0] res_3;
    logic [2:0]  flg_3;

    int total = 0;
    int bad = 0;

    dp_sequencer #(.EXEC_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(valid1), .instr_ready(ready1),
        .instr(instr1), .read1(rd1_1), .read2(rd2_1), .write(wr_1), .op(op_1),
        .inm(inm_1), .sel(sel_1), .reg_we(we_1), .dp_result(dp_result),
        .dp_zero(dp_zero), .dp_overflow(dp_overflow), .dp_carry(dp_carry),
        .done(done_1), .illegal(ill_1), .ovf_trap(trap_1), .result_q(res_1),
        .flags_q(flg_1)
    );

    dp_sequencer #(.EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(valid3), .instr_ready(ready3),
        .instr(instr3), .read1(rd1_3), .read2(rd2_3), .write(wr_3), .op(op_3),
        .inm(inm_3), .sel(sel_3), .reg_we(we_3), .dp_result(dp_result),
        .dp_zero(dp_zero), .dp_overflow(dp_overflow), .dp_carry(dp_carry),
        .done(done_3), .illegal(ill_3), .ovf_trap(trap_3), .result_q(res_3),
        .flags_q(flg_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w);
        instr1 = w;
        valid1 = 1'b1;
        step();
        valid1 = 1'b0;
    endtask

    initial begin
        int seen [$];
        rst_n = 1'b0;
        valid1 = 1'b0; instr1 = '0;
        valid3 = 1'b0; instr3 = '0;
        dp_result = '0; dp_zero = 1'b0; dp_overflow = 1'b0; dp_carry = 1'b0;

        #2;
        chk("rst_ready", 32'(ready1), 32'h0);
        chk("rst_done", 32'(done_1), 32'h0);
        chk("rst_we", 32'(we_1), 32'h0);
        chk("rst_result", res_1, 32'h0);
        chk("rst_flags", 32'(flg_1), 32'h0);
        chk("rst_read1", 32'(rd1_1), 32'h0);
        #10 rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(ready1), 32'h1);

        // add $3,$1,$2
        issue(32'h00221820);
        chk("add_read1", 32'(rd1_1), 32'd1);
        chk("add_read2", 32'(rd2_1), 32'd2);
        chk("add_write", 32'(wr_1), 32'd3);
        chk("add_op", 32'(op_1), 32'b0010);
        chk("add_sel", 32'(sel_1), 32'h0);
        chk("add_busy_ready", 32'(ready1), 32'h0);
        chk("add_dec_we", 32'(we_1), 32'h0);
        dp_result = 32'h00000007;
        step();
        chk("add_exec_we", 32'(we_1), 32'h0);
        chk("add_exec_op", 32'(op_1), 32'b0010);
        step();
        chk("add_wb_we", 32'(we_1), 32'h1);
        chk("add_wb_done", 32'(done_1), 32'h0);
        step();
        chk("add_k3_done", 32'(done_1), 32'h0);
        chk("add_k3_we", 32'(we_1), 32'h0);
        chk("add_result", res_1, 32'h00000007);
        chk("add_done_fields", 32'(op_1), 32'h0);
        step();
        chk("add_k4_done", 32'(done_1), 32'h1);
        chk("add_illegal", 32'(ill_1), 32'h0);
        chk("add_trap", 32'(trap_1), 32'h0);
        chk("add_flags", 32'(flg_1), 32'h0);
        step();
        chk("add_done_pulse", 32'(done_1), 32'h0);

        // addi $2,$1,-1
        issue(32'h2022FFFF);
        chk("addi_sel", 32'(sel_1), 32'h1);
        chk("addi_inm", 32'(inm_1), 32'hFFFF);
        chk("addi_write", 32'(wr_1), 32'd2);
        chk("addi_op", 32'(op_1), 32'b0010);
        step();
        step();
        chk("addi_we", 32'(we_1), 32'h1);
        step();
        step();
        chk("addi_done", 32'(done_1), 32'h1);
        chk("addi_trap", 32'(trap_1), 32'h0);

        // add with overflow traps and suppresses the write
        dp_overflow = 1'b1; dp_carry = 1'b1; dp_result = 32'h80000000;
        issue(32'h00221820);
        step();
        step();
        chk("ovf_we", 32'(we_1), 32'h0);
        step();
        chk("ovf_flags", 32'(flg_1), 32'b011);
        chk("ovf_result", res_1, 32'h80000000);
        step();
        chk("ovf_done", 32'(done_1), 32'h1);
        chk("ovf_trap", 32'(trap_1), 32'h1);

        // or with the same flags never traps
        issue(32'h00221825);
        chk("or_trap_cleared", 32'(trap_1), 32'h0);
        chk("or_op", 32'(op_1), 32'b0001);
        step();
        step();
        chk("or_we", 32'(we_1), 32'h1);
        step();
        step();
        chk("or_done", 32'(done_1), 32'h1);
        chk("or_trap", 32'(trap_1), 32'h0);
        dp_overflow = 1'b0; dp_carry = 1'b0;

        // lw is illegal
        issue(32'h8C220004);
        step();
        chk("lw_k1_done", 32'(done_1), 32'h0);
        chk("lw_k1_we", 32'(we_1), 32'h0);
        chk("lw_k1_write", 32'(wr_1), 32'h0);
        chk("lw_k1_read1", 32'(rd1_1), 32'h0);
        step();
        chk("lw_k2_done", 32'(done_1), 32'h1);
        chk("lw_illegal", 32'(ill_1), 32'h1);
        chk("lw_k2_we", 32'(we_1), 32'h0);

        // add $0,$1,$2: no write, not an error
        dp_result = 32'h00000007;
        issue(32'h00220020);
        chk("z_illegal_cleared", 32'(ill_1), 32'h0);
        step();
        chk("z_exec_we", 32'(we_1), 32'h0);
        step();
        chk("z_wb_we", 32'(we_1), 32'h0);
        step();
        chk("z_k3_we", 32'(we_1), 32'h0);
        step();
        chk("z_done", 32'(done_1), 32'h1);
        chk("z_illegal", 32'(ill_1), 32'h0);
        chk("z_trap", 32'(trap_1), 32'h0);

        // back-to-back on the EXEC_CYCLES=3 instance
        instr3 = 32'h00221820;
        valid3 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready3) seen.push_back(i);
        end
        valid3 = 1'b0;
        chk("b2b_count_ge3", 32'(seen.size() >= 3), 32'h1);
        if (seen.size() >= 3) begin
            chk("b2b_gap1", 32'(seen[1] - seen[0]), 32'd7);
            chk("b2b_gap2", 32'(seen[2] - seen[1]), 32'd7);
        end
        chk("b2b_first_ready", 32'(seen.size() > 0 ? seen[0] : -1), 32'd6);
        step();
        step();
        step();
        step();
        step();
        step();
        step();
        step();

        // reset asserted during EXEC
        dp_result = 32'h00000055;
        issue(32'h00221820);
        step();
        chk("pre_rst_op", 32'(op_1), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_read1", 32'(rd1_1), 32'h0);
        chk("mid_rst_write", 32'(wr_1), 32'h0);
        chk("mid_rst_op", 32'(op_1), 32'h0);
        chk("mid_rst_inm", 32'(inm_1), 32'h0);
        chk("mid_rst_we", 32'(we_1), 32'h0);
        chk("mid_rst_done", 32'(done_1), 32'h0);
        chk("mid_rst_ready", 32'(ready1), 32'h0);
        chk("mid_rst_result", res_1, 32'h0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_done", 32'(done_1), 32'h0);
            chk("post_rst_we", 32'(we_1), 32'h0);
        end
        chk("post_rst_ready", 32'(ready1), 32'h1);
        chk("post_rst_result", res_1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
Multi-cycle control unit that fetches one 32-bit MIPS instruction per handshake, decodes it and drives the control fields of the register-file/ALU datapath (dp). It holds the fields while the datapath settles, samples the result and flags, and issues a register write enable. It reports completion, illegal instructions and arithmetic-overflow traps. It sits between the instruction source and dp.

Parameters:
EXEC_CYCLES, 1, cycles the control fields are held in EXEC before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept; high only in IDLE
instr  input  32  MIPS instruction word
read1  output  5  dp read port 1 address (rs)
read2  output  5  dp read port 2 address (rt)
write  output  5  dp write address
op  output  4  dp ALU op
inm  output  16  dp immediate, instr[15:0], forwarded unmodified
sel  output  1  dp operand-B select: 0 = register, 1 = immediate
reg_we  output  1  register write enable, one-cycle pulse
dp_result  input  32  dp ALU result
dp_zero  input  1  dp zero flag
dp_overflow  input  1  dp overflow flag
dp_carry  input  1  dp carry flag
done  output  1  one-cycle completion pulse
illegal  output  1  valid with done: instruction not decoded
ovf_trap  output  1  valid with done: overflow trap, write suppressed
result_q  output  32  result captured in WB
flags_q  output  3  {zero, overflow, carry} captured in WB

Behaviour:
- Reset, asynchronous and active-low: state goes to IDLE and every output is 0, including reg_we, done, result_q and flags_q. instr_ready is 1 once out of reset.
- States and transitions:
  - IDLE: accepts an instruction when instr_valid && instr_ready; instr is latched and the next state is DECODE.
  - DECODE: goes to EXEC, or to DONE with illegal=1 when the instruction does not decode.
  - EXEC: a counter holds this state for exactly EXEC_CYCLES cycles, then goes to WB.
  - WB: always goes to DONE.
  - DONE: always returns to IDLE.
- Control fields are driven from DECODE through WB inclusive and are 0 in IDLE and DONE.
- R-type decode (opcode 000000): read1=rs, read2=rt, write=rd, sel=0. funct to op mapping:
  - 100100 and -> 0000
  - 100101 or -> 0001
  - 100000 add -> 0010
  - 100010 sub -> 0110
  - 101010 slt -> 0111
  - 100111 nor -> 1100
- I-type decode: read1=rs, read2=rt, write=rt, sel=1. opcode to op mapping:
  - 001100 andi -> 0000
  - 001101 ori -> 0001
  - 001000 addi -> 0010
  - 001010 slti -> 0111
- Any other opcode or funct is illegal: no EXEC, no WB, no reg_we.
- WB: result_q and flags_q capture dp_result and {dp_zero, dp_overflow, dp_carry}. reg_we=1 for this one cycle unless either condition holds:
  - a trap: dp_overflow=1 on add, sub or addi; this sets ovf_trap.
  - write==0, since $0 is never written. This is not an error.
- Logical ops and slt/slti never trap.
- DONE: done=1 for one cycle. illegal and ovf_trap are valid with done and cleared on the next instruction accept. result_q and flags_q hold until the next WB.
- Latency: accept on edge k leads to done high after edge k+3+EXEC_CYCLES. For illegal instructions, done is high after edge k+2.
- instr_valid held high while busy: no accept occurs until IDLE, so there is exactly one instruction in flight.
- Reset asserted mid-operation: the instruction is aborted immediately. No reg_we and no done are produced for it.

Decomposition:
- Package dp_ctrl_pkg: opcode and funct constants, ALU op codes, state enum (IDLE, DECODE, EXEC, WB, DONE).
- Sub-module dp_instr_decode: purely combinational. Maps instr to read1, read2, write, op, sel, may_trap and illegal.
- The FSM, EXEC counter and capture registers stay in dp_sequencer.

Test Plan:
- add $3,$1,$2 (0x00221820), EXEC_CYCLES=1, dp_result stubbed to 0x00000007:
  - read1=1, read2=2, write=3, op=0010, sel=0.
  - reg_we pulses in WB; done after edge k+4; result_q=0x00000007.
- addi $2,$1,-1 (0x2022FFFF):
  - sel=1, inm=0xFFFF, write=2, op=0010.
  - reg_we pulses; ovf_trap=0.
- add with dp_overflow=1, dp_carry=1:
  - ovf_trap=1, reg_we stays 0, flags_q=3'b011.
  - The same stimulus on or (0x00221825) gives reg_we=1 and ovf_trap=0.
- lw 0x8C220004 (illegal):
  - illegal=1 and done after edge k+2.
  - No reg_we, and the control fields stay 0 apart from DECODE.
- add $0,$1,$2 (0x00220020): reg_we never asserts, done=1, illegal=0.
- Back-to-back and reset:
  - With instr_valid held high and EXEC_CYCLES=3, accepts occur every 7 cycles.
  - rst_n low during EXEC forces all outputs to 0 at once; no done is produced; instr_ready=1 after release.
